alu_share_arbiter: RTL

Shares one combinational ALU (32-bit operands, 4-bit op code, Result/Zero outputs) among NUM_REQ requesters, such as the main execute path and an address-generation/CSR helper.
- Arbitrates round-robin and drives the ALU from registered operands.
- Registers Result/Zero and returns them to the granted requester over a valid/ready response channel tagged with the requester id.

---
 rtl/alu_share_arbiter.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//
// Purpose:
//   Time-shares one external combinational ALU between NUM_REQ requesters.
//   A round-robin arbiter accepts one request at a time in IDLE. The accepted
//   operands are registered and drive the ALU during EXEC. The ALU result and
//   zero flag are registered at the end of EXEC. They are then offered to the
//   owning requester on a valid/ready response channel tagged with its id.
//   Sequence: IDLE -> EXEC -> RESP -> IDLE, so at most one op every 3 cycles.
//
// Optional build macro:
//   ALU_ILLEGAL_OP_CHECK_EN
//     When defined, the block adds an rsp_err output.
//     Op codes 4'hA..4'hF are flagged at accept. For a flagged op the response
//     carries rsp_err=1, rsp_result=0 and rsp_zero=1. The op still goes
//     through EXEC and RESP with the same timing.
//     When undefined, there is no rsp_err port. Every op code is passed to
//     the ALU, and the ALU output is returned unchanged.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   req_valid/req_ready    per-requester handshake; req_ready is one-hot or 0
//   req_a/req_b/req_op     packed operands; requester i uses slice i
//   alu_a/alu_b/alu_op     registered operands driven to the shared ALU
//   alu_result/alu_zero    outputs of the shared ALU
//   rsp_valid/rsp_ready    response handshake
//   rsp_id                 index of the requester that owns the response
//   rsp_result/rsp_zero    registered ALU result and zero flag
//   rsp_err                illegal-op flag (only with ALU_ILLEGAL_OP_CHECK_EN)
//   busy                   high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  input  logic [4*NUM_REQ-1:0]  req_op,
  output logic [31:0]           alu_a,
  output logic [31:0]           alu_b,
  output logic [3:0]            alu_op,
  input  logic [31:0]           alu_result,
  input  logic                  alu_zero,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_result,
  output logic                  rsp_zero,
`ifdef ALU_ILLEGAL_OP_CHECK_EN
  output logic                  rsp_err,
`endif
  output logic                  busy
);

  localparam int ID_SPACE = 1 << ID_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t          state_q,      state_d;
  logic [31:0]     op_a_q,       op_a_d;
  logic [31:0]     op_b_q,       op_b_d;
  logic [3:0]      op_code_q,    op_code_d;
  logic [ID_W-1:0] last_q,       last_d;
  logic [ID_W-1:0] rsp_id_q,     rsp_id_d;
  logic [31:0]     rsp_result_q, rsp_result_d;
  logic            rsp_zero_q,   rsp_zero_d;
  logic            rsp_valid_q,  rsp_valid_d;
  logic            busy_q,       busy_d;
`ifdef ALU_ILLEGAL_OP_CHECK_EN
  logic            err_q,        err_d;
`endif

  // The request vectors are widened to the full id space. This lets the
  // arbiter index them with an ID_W-bit index. Ids at or above NUM_REQ read
  // as idle/zero and are never granted.
  logic [ID_SPACE-1:0] valid_ext;
  logic [31:0]         a_arr  [ID_SPACE];
  logic [31:0]         b_arr  [ID_SPACE];
  logic [3:0]          op_arr [ID_SPACE];

  for (genvar gi = 0; gi < ID_SPACE; gi++) begin : g_unpack
    if (gi < NUM_REQ) begin : g_real
      assign valid_ext[gi] = req_valid[gi];
      assign a_arr[gi]     = req_a[32*gi +: 32];
      assign b_arr[gi]     = req_b[32*gi +: 32];
      assign op_arr[gi]    = req_op[4*gi +: 4];
    end else begin : g_pad
      assign valid_ext[gi] = 1'b0;
      assign a_arr[gi]     = '0;
      assign b_arr[gi]     = '0;
      assign op_arr[gi]    = '0;
    end
  end

  // Round-robin search. It starts one past the last grant and wraps modulo
  // NUM_REQ, so the most recently served requester has the lowest priority.
  logic            grant_vld;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] cand;
  int              cand_int;

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    cand_int  = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_int = (int'(last_q) + k) % NUM_REQ;
      cand     = ID_W'(cand_int);
      if (!grant_vld && valid_ext[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Grants are offered only in IDLE. Because the grant is derived from
  // req_valid, a high ready bit always means the handshake completes.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
    assign req_ready[gi] = (state_q == ST_IDLE) && grant_vld &&
                           (grant_idx == ID_W'(gi));
  end

  always_comb begin
    state_d      = state_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_code_d    = op_code_q;
    last_d       = last_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_valid_d  = rsp_valid_q;
    busy_d       = busy_q;
`ifdef ALU_ILLEGAL_OP_CHECK_EN
    err_d        = err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          op_a_d    = a_arr[grant_idx];
          op_b_d    = b_arr[grant_idx];
          op_code_d = op_arr[grant_idx];
          rsp_id_d  = grant_idx;
          last_d    = grant_idx;
          state_d   = ST_EXEC;
          busy_d    = 1'b1;
`ifdef ALU_ILLEGAL_OP_CHECK_EN
          err_d     = (op_arr[grant_idx] >= 4'hA);
`endif
        end
      end

      ST_EXEC: begin
`ifdef ALU_ILLEGAL_OP_CHECK_EN
        // A flagged op returns a fixed, recognisable value instead of
        // whatever the ALU produces for an undefined code.
        rsp_result_d = err_q ? 32'd0 : alu_result;
        rsp_zero_d   = err_q ? 1'b1  : alu_zero;
`else
        rsp_result_d = alu_result;
        rsp_zero_d   = alu_zero;
`endif
        rsp_valid_d  = 1'b1;
        state_d      = ST_RESP;
      end

      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        rsp_valid_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_code_q    <= '0;
      last_q       <= ID_W'(NUM_REQ - 1);  // requester 0 wins first
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
`ifdef ALU_ILLEGAL_OP_CHECK_EN
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_code_q    <= op_code_d;
      last_q       <= last_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_valid_q  <= rsp_valid_d;
      busy_q       <= busy_d;
`ifdef ALU_ILLEGAL_OP_CHECK_EN
      err_q        <= err_d;
`endif
    end
  end

  assign alu_a      = op_a_q;
  assign alu_b      = op_b_q;
  assign alu_op     = op_code_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign busy       = busy_q;
`ifdef ALU_ILLEGAL_OP_CHECK_EN
  assign rsp_err    = err_q;
`endif

endmodule
